// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: sums N_INPUTS words over LOG2N registered levels,
// with optional divide-by-N scaling and WORD_SIZE saturation folded into the last level.
module adder_tree_pipe #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned N_INPUTS  = 4,
    localparam int unsigned LOG2N    = $clog2(N_INPUTS),
    localparam int unsigned OUT_W    = WORD_SIZE + LOG2N
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic                          i_valid,
    input  logic                          i_scale,
    input  logic [N_INPUTS*WORD_SIZE-1:0] i_data,
    output logic                          o_valid,
    output logic signed [OUT_W-1:0]       o_sum,
    output logic [WORD_SIZE-1:0]          o_sat,
    output logic                          o_ovf
);

    localparam int unsigned TOP = LOG2N - 1;

    for (genvar j = 0; j < LOG2N; j++) begin : g_lvl
        localparam int unsigned IW  = WORD_SIZE + j;
        localparam int unsigned CNT = N_INPUTS >> (j + 1);

        logic signed [IW:0] sum_d [CNT];
        logic               v_in;
        logic               s_in;

        if (j == 0) begin : g_src
            assign v_in = i_valid;
            assign s_in = i_scale;
        end else begin : g_src
            assign v_in = g_lvl[j-1].g_reg.valid_q;
            assign s_in = g_lvl[j-1].g_reg.scale_q;
        end

        for (genvar k = 0; k < CNT; k++) begin : g_add
            logic signed [IW-1:0] a;
            logic signed [IW-1:0] b;
            if (j == 0) begin : g_op
                assign a = i_data[2*k*WORD_SIZE +: WORD_SIZE];
                assign b = i_data[(2*k+1)*WORD_SIZE +: WORD_SIZE];
            end else begin : g_op
                assign a = g_lvl[j-1].g_reg.sum_q[2*k];
                assign b = g_lvl[j-1].g_reg.sum_q[2*k+1];
            end
            // One guard bit per level keeps every partial sum exact.
            assign sum_d[k] = {a[IW-1], a} + {b[IW-1], b};
        end

        // The last level registers straight into the output stage below.
        if (j + 1 < LOG2N) begin : g_reg
            logic signed [IW:0] sum_q [CNT];
            logic               valid_q;
            logic               scale_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    valid_q <= 1'b0;
                    scale_q <= 1'b0;
                    for (int unsigned m = 0; m < CNT; m++) begin
                        sum_q[m] <= '0;
                    end
                end else if (i_en) begin
                    valid_q <= v_in;
                    scale_q <= s_in;
                    sum_q   <= sum_d;
                end
            end
        end
    end

    logic signed [OUT_W-1:0] full_sum;
    logic signed [OUT_W-1:0] res;
    logic [LOG2N:0]          hi_bits;
    logic                    clip;
    logic [WORD_SIZE-1:0]    sat_d;

    assign full_sum = g_lvl[TOP].sum_d[0];
    assign res      = g_lvl[TOP].s_in ? (full_sum >>> LOG2N) : full_sum;

    // Result fits in WORD_SIZE only if all bits from the WORD_SIZE sign bit up agree.
    assign hi_bits = res[OUT_W-1:WORD_SIZE-1];
    assign clip    = !((&hi_bits) || !(|hi_bits));
    assign sat_d   = clip ? {res[OUT_W-1], {(WORD_SIZE-1){~res[OUT_W-1]}}}
                          : res[WORD_SIZE-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_sat   <= '0;
            o_ovf   <= 1'b0;
        end else if (i_en) begin
            o_valid <= g_lvl[TOP].v_in;
            o_sum   <= res;
            o_sat   <= sat_d;
            o_ovf   <= g_lvl[TOP].v_in & clip;
        end
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe: a 4-input and a 2-input instance, directed vectors.
module tb_adder_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic               en4, valid4, scale4;
    logic [63:0]        data4;
    logic               v4o;
    logic signed [17:0] sum4;
    logic [15:0]        sat4;
    logic               ovf4;

    logic               en2, valid2, scale2;
    logic [31:0]        data2;
    logic               v2o;
    logic signed [16:0] sum2;
    logic [15:0]        sat2;
    logic               ovf2;

    adder_tree_pipe #(.WORD_SIZE(16), .N_INPUTS(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_en(en4), .i_valid(valid4), .i_scale(scale4),
        .i_data(data4), .o_valid(v4o), .o_sum(sum4), .o_sat(sat4), .o_ovf(ovf4)
    );

    adder_tree_pipe #(.WORD_SIZE(16), .N_INPUTS(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_en(en2), .i_valid(valid2), .i_scale(scale2),
        .i_data(data2), .o_valid(v2o), .o_sum(sum2), .o_sat(sat2), .o_ovf(ovf2)
    );

    typedef struct {
        string       name;
        int          sum;
        logic [15:0] sat;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q4[$];
    exp_t q2[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic e4_edge = 1'b0;
    logic e2_edge = 1'b0;

    // A result is new only if the edge that produced it was enabled.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        e4_edge <= en4;
        e2_edge <= en2;
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (v4o && e4_edge) begin
            n_cmp++;
            if (q4.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected4: got o_valid=1 sum=%0d at cyc %0d, want no result",
                         sum4, cyc);
            end else begin
                e = q4.pop_front();
                if (sum4 != e.sum || sat4 != e.sat || ovf4 != e.ovf || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL %s: got sum=%0d sat=%h ovf=%b cyc=%0d, want sum=%0d sat=%h ovf=%b cyc=%0d",
                             e.name, sum4, sat4, ovf4, cyc, e.sum, e.sat, e.ovf, e.due);
                end
            end
        end else if (!v4o) begin
            n_cmp++;
            if (ovf4 !== 1'b0) begin
                n_bad++;
                $display("FAIL ovf_idle4: got o_ovf=%b with o_valid=0, want 0", ovf4);
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (v2o && e2_edge) begin
            n_cmp++;
            if (q2.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected2: got o_valid=1 sum=%0d at cyc %0d, want no result",
                         sum2, cyc);
            end else begin
                e = q2.pop_front();
                if (sum2 != e.sum || sat2 != e.sat || ovf2 != e.ovf || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL %s: got sum=%0d sat=%h ovf=%b cyc=%0d, want sum=%0d sat=%h ovf=%b cyc=%0d",
                             e.name, sum2, sat2, ovf2, cyc, e.sum, e.sat, e.ovf, e.due);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic push4(input string nm, input int s, input logic [15:0] sat,
                         input logic ovf, input int extra);
        exp_t e;
        e.name = nm; e.sum = s; e.sat = sat; e.ovf = ovf; e.due = cyc + 2 + extra;
        q4.push_back(e);
    endtask

    task automatic send4(input string nm, input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3, input logic sc,
                         input int s, input logic [15:0] sat, input logic ovf);
        en4 = 1'b1; valid4 = 1'b1; scale4 = sc; data4 = {w3, w2, w1, w0};
        push4(nm, s, sat, ovf, 0);
        @(negedge clk);
        valid4 = 1'b0;
    endtask

    task automatic send2(input string nm, input logic [15:0] w0, input logic [15:0] w1,
                         input logic sc, input int s, input logic [15:0] sat, input logic ovf);
        exp_t e;
        en2 = 1'b1; valid2 = 1'b1; scale2 = sc; data2 = {w1, w0};
        e.name = nm; e.sum = s; e.sat = sat; e.ovf = ovf; e.due = cyc + 1;
        q2.push_back(e);
        @(negedge clk);
        valid2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en4 = 1'b0; valid4 = 1'b0; scale4 = 1'b0; data4 = '0;
        en2 = 1'b0; valid2 = 1'b0; scale2 = 1'b0; data2 = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", int'(v4o), 0);
        chk("reset_sum", int'(sum4), 0);
        chk("reset_sat", int'(sat4), 0);
        rst = 1'b0; en4 = 1'b1; en2 = 1'b1;
        @(negedge clk);

        send4("basic", 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 10, 16'd10, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("basic_one_cycle", int'(v4o), 0);

        // Back-to-back directed vectors.
        send4("ovf_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 131068, 16'h7FFF, 1'b1);
        send4("ovf_neg", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, -131072, 16'h8000, 1'b1);
        send4("scaled_floor", 16'hFFF8, 16'hFFF8, 16'hFFF8, 16'hFFF9, 1'b1, -8, 16'hFFF8, 1'b0);
        send4("scaled_max", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 32767, 16'h7FFF, 1'b0);
        send4("mixed", 16'd100, 16'hFFCE, 16'd7, 16'hFF38, 1'b0, -143, 16'hFF71, 1'b0);
        send4("edge_max", 16'h4000, 16'h4000, 16'h0000, 16'hFFFF, 1'b0, 32767, 16'h7FFF, 1'b0);
        send4("edge_clip", 16'h4000, 16'h4000, 16'h0000, 16'h0000, 1'b0, 32768, 16'h7FFF, 1'b1);
        send4("edge_min", 16'hC000, 16'hC000, 16'h0000, 16'h0000, 1'b0, -32768, 16'h8000, 1'b0);
        send4("edge_clip_neg", 16'hC000, 16'hC000, 16'hFFFF, 16'h0000, 1'b0, -32769, 16'h8000,
              1'b1);
        send4("scaled_small", 16'd1, 16'd1, 16'd1, 16'd0, 1'b1, 0, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);

        // Stream with a two-cycle stall after the second sample.
        send4("stream_a", 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 4, 16'd4, 1'b0);
        valid4 = 1'b1; data4 = {4{16'd2}};
        push4("stream_b", 8, 16'd8, 1'b0, 2);
        @(negedge clk);
        en4 = 1'b0; valid4 = 1'b1; data4 = {4{16'h1234}};
        @(negedge clk);
        chk("stall1_valid", int'(v4o), 1);
        chk("stall1_sum", int'(sum4), 4);
        @(negedge clk);
        chk("stall2_valid", int'(v4o), 1);
        chk("stall2_sat", int'(sat4), 4);
        send4("stream_c", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, -4, 16'hFFFC, 1'b0);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-cycle while a result is showing.
        send4("pre_reset", 16'd5, 16'd6, 16'd7, 16'd8, 1'b0, 26, 16'd26, 1'b0);
        @(negedge clk);
        #2;
        chk("pre_reset_valid", int'(v4o), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(v4o), 0);
        chk("async_rst_sum", int'(sum4), 0);
        chk("async_rst_sat", int'(sat4), 0);
        chk("async_rst_ovf", int'(ovf4), 0);
        #1;
        rst = 1'b0;
        valid4 = 1'b1; scale4 = 1'b0; data4 = {4{16'd3}};
        push4("after_reset", 12, 16'd12, 1'b0, 0);
        @(negedge clk);
        valid4 = 1'b0;
        repeat (3) @(negedge clk);

        // Flush: two samples in flight are discarded by reset.
        valid4 = 1'b1; data4 = {4{16'd9}};
        @(negedge clk);
        data4 = {4{16'd10}};
        @(posedge clk);
        #1;
        rst = 1'b1; valid4 = 1'b0;
        #2;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush_no_valid", int'(v4o), 0);

        send2("n2_basic", 16'd5, 16'hFFFD, 1'b0, 2, 16'd2, 1'b0);
        send2("n2_clip", 16'h7FFF, 16'h7FFF, 1'b0, 65534, 16'h7FFF, 1'b1);
        send2("n2_scaled", 16'hFFFD, 16'h0000, 1'b1, -2, 16'hFFFE, 1'b0);
        send2("n2_neg_clip", 16'h8000, 16'hFFFF, 1'b0, -32769, 16'h8000, 1'b1);

        for (int i = 0; i < 20; i++) begin
            if (q4.size() == 0 && q2.size() == 0) break;
            @(negedge clk);
        end
        if (q4.size() != 0 || q2.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d+%0d results outstanding, want 0", q4.size(), q2.size());
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
